// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq: serialises an M-bit request vector into a stream of set-bit indices, lowest first.
// Define PEND_COUNT_EN to add the registered pend_cnt popcount output.
module priority_encoder_seq #(
    parameter int N = 4,
    parameter int M = (1 << N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_idx,
    output logic         out_last,
`ifdef PEND_COUNT_EN
    output logic [N:0]   pend_cnt,
`endif
    output logic         zero_flag
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    if (M < 2 || M > (1 << N)) begin : g_bad_m
        $error("priority_encoder_seq: M must satisfy 2 <= M <= 2**N");
    end
    logic [0:0]   state;
    logic [M-1:0] pend;
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == EMIT);
    assign out_last  = (pend != '0) && ((pend & (pend - M'(1))) == '0);
    // Scan from the top so the lowest set bit is the last to write out_idx.
    always_comb begin
        out_idx = '0;
        for (int i = M - 1; i >= 0; i--) out_idx = pend[i] ? N'(i) : out_idx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            zero_flag <= 1'b0;
        end else begin
            zero_flag <= (state == IDLE) && in_valid && (in_vec == '0);
            if (state == IDLE) begin
                if (in_valid && in_vec != '0) begin
                    pend  <= in_vec;
                    state <= EMIT;
                end
            end else if (out_ready) begin
                pend <= pend & (pend - M'(1));
                if (out_last) state <= IDLE;
            end
        end
    end
`ifdef PEND_COUNT_EN
    function automatic logic [N:0] popcnt(input logic [M-1:0] v);
        popcnt = '0;
        for (int i = 0; i < M; i++) popcnt = popcnt + {{N{1'b0}}, v[i]};
    endfunction
    always_ff @(posedge clk) begin
        if (rst) pend_cnt <= '0;
        else if (state == IDLE && in_valid) pend_cnt <= popcnt(in_vec);
        else if (state == EMIT && out_ready) pend_cnt <= pend_cnt - (N+1)'(1);
    end
`endif
endmodule

// File: tb/tb_priority_encoder_seq.sv
// tb_priority_encoder_seq: scoreboard bench; a predictor queues the expected index stream per accepted vector.
module tb_priority_encoder_seq;
    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b1;
    logic [15:0] in_vec = 16'h000A;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_last, zero_flag;
    logic [3:0]  out_idx;
`ifdef PEND_COUNT_EN
    logic [4:0]  pend_cnt;
`endif
    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic        ezf = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  pidx;
    logic        plast;

    priority_encoder_seq #(.N(4), .M(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
`ifdef PEND_COUNT_EN
        .pend_cnt(pend_cnt),
`endif
        .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        step();
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        step();
        out_ready = 1'b1;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Predictor: every accepted vector becomes its list of set bits, lowest first.
    always @(negedge clk) begin
        if (!rst) chk("zero_flag", zero_flag, ezf);
        ezf = !rst && in_valid && in_ready && in_vec == 16'h0;
        if (!rst && in_valid && in_ready && in_vec != 16'h0) begin
            int top = 0;
            for (int i = 0; i < 16; i++) if (in_vec[i]) top = i;
            for (int i = 0; i < 16; i++) if (in_vec[i]) q.push_back('{idx: 4'(i), last: (i == top)});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_idx", out_idx, pidx);
                chk("stall_last", out_last, plast);
            end
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
                else if (out_ready) begin
                    exp_t e;
`ifdef PEND_COUNT_EN
                    chk("pend_cnt", pend_cnt, q.size());
`endif
                    e = q.pop_front();
                    chk("out_idx", out_idx, e.idx);
                    chk("out_last", out_last, e.last);
                end
            end else begin
`ifdef PEND_COUNT_EN
                chk("pend_cnt_idle", pend_cnt, 0);
`endif
            end
            stall = out_valid && !out_ready;
            pidx  = out_idx;
            plast = out_last;
        end
    end

    initial begin
        forever begin
            step();
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_zero_flag", zero_flag, 0);
        end
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_idx", out_idx, 0);

        step();
        out_ready = 1'b1;
        send(16'h8421);
        repeat (4) begin
            @(negedge clk);
            chk("stream_valid", out_valid, 1);
        end
        @(negedge clk);
        chk("stream_done_valid", out_valid, 0);
        chk("stream_done_ready", in_ready, 1);
        chk("stream_queue_empty", q.size(), 0);

        step();
        out_ready = 1'b0;
        send(16'h0006);
        repeat (5) begin
            @(negedge clk);
            chk("bp_idx", out_idx, 1);
        end
        step();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("bp_done_valid", out_valid, 0);
        chk("bp_queue_empty", q.size(), 0);

        send(16'h0000);
        @(negedge clk);
        chk("zero_pulse", zero_flag, 1);
        chk("zero_no_valid", out_valid, 0);
        @(negedge clk);
        chk("zero_pulse_end", zero_flag, 0);
        chk("zero_in_ready", in_ready, 1);

        send(16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_in_ready", in_ready, 1);
        send(16'h0010);
        repeat (2) @(negedge clk);
        chk("after_rst_valid", out_valid, 0);
        chk("after_rst_queue_empty", q.size(), 0);

        send(16'h8000);
        drain();
        send(16'hFFFF);
        drain();
`ifdef PEND_COUNT_EN
        send(16'h0007);
        drain();
`endif

        rand_rdy = 1'b1;
        repeat (60) begin
            int r = $urandom_range(0, 9);
            send(r == 0 ? 16'h0 : r == 1 ? 16'h1 << $urandom_range(0, 15) : 16'($urandom));
        end
        rand_rdy = 1'b0;
        drain();
        @(negedge clk);
        chk("final_idle_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
